// File: rtl/data_mem_responder.sv
// Word-addressed data-memory target for the CPU load/store port.
// Serves one request at a time, stalls WAIT_CYCLES, then pulses ack (with err) for one cycle.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [31:0]   dout_q;
  logic [31:0]   mem [DEPTH];

  logic op_ok, align_ok, range_ok, req_valid;
  logic done_entry, mem_we;

  // Every upper address bit must be clear: out-of-range words never alias into the array.
  assign op_ok     = MemRead ^ MemWrite;
  assign align_ok  = (addr[1:0] == 2'b00);
  assign range_ok  = (addr[31:AW+2] == '0);
  assign req_valid = op_ok & align_ok & range_ok;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          idx_d   = addr[AW+1:2];
          wdata_d = data_in;
          wr_d    = MemWrite;
          err_d   = ~req_valid;
          if (!req_valid || WAIT_CYCLES == 0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // The _d copies carry either the freshly accepted request or the latched one,
  // so the array access on DONE entry works for zero and non-zero wait states alike.
  assign done_entry = (state_d == ST_DONE) && (state_q != ST_DONE);
  assign mem_we     = done_entry && wr_d && !err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (rst_n && mem_we) begin
      mem[idx_d] <= wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q <= 32'd0;
    end else if (done_entry) begin
      if (err_d) begin
        dout_q <= 32'd0;
      end else if (!wr_d) begin
        dout_q <= mem[idx_d];
      end
    end
  end

  assign data_out = dout_q;
  assign busy     = (state_q != ST_IDLE);
  assign ack      = (state_q == ST_DONE);
  assign err      = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized scoreboard bench for data_mem_responder, plus a zero-wait-state
// instance exercising back-to-back accesses with req held high.
module tb_data_mem_responder;
  localparam int DEPTH = 256;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0, MemRead = 1'b0, MemWrite = 1'b0;
  logic [31:0] addr = 32'd0, data_in = 32'd0;
  logic [31:0] data_out;
  logic        ack, err, busy;

  logic        req0 = 1'b0, rd0 = 1'b0, wr0 = 1'b0;
  logic [31:0] addr0 = 32'd0, din0 = 32'd0;
  logic [31:0] dout0;
  logic        ack0, err0, busy0;

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(WC)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .data_in(data_in), .data_out(data_out), .ack(ack), .err(err), .busy(busy)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .MemRead(rd0), .MemWrite(wr0),
    .addr(addr0), .data_in(din0), .data_out(dout0), .ack(ack0), .err(err0), .busy(busy0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        err;
    logic [31:0] data;
    bit          data_known;
    int          ack_cyc;
    logic [31:0] addr;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] ref_mem [DEPTH];
  bit          ref_known [DEPTH];
  logic [31:0] exp_dout = 32'd0;
  bit          exp_dout_known = 1'b1;
  int          n_txn = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (ack) begin
        if (sb_q.size() == 0) begin
          check("ack_without_request", {31'd0, ack}, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("ack_cycle", 32'(cyc), 32'(e.ack_cyc));
          check("err", {31'd0, err}, {31'd0, e.err});
          if (e.data_known) check("data_out", data_out, e.data);
          n_txn++;
          $display("txn %0d addr=%h err=%0b data_out=%h", n_txn, e.addr, err, data_out);
        end
      end else begin
        check("err_without_ack", {31'd0, err}, 32'd0);
      end
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit   valid;
    int   w;
    int   t;
    exp_t e;
    @(negedge clk);
    t = 0;
    while (busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      check("idle_timeout", {31'd0, busy}, 32'd0);
      return;
    end
    valid = ((rd ^ wr) == 1'b1) && (a % 4 == 0) && ((a / 4) < DEPTH);
    w = int'(a / 4);
    if (!valid) begin
      exp_dout = 32'd0;
      exp_dout_known = 1'b1;
    end else if (wr) begin
      ref_mem[w] = d;
      ref_known[w] = 1'b1;
    end else begin
      exp_dout = ref_mem[w];
      exp_dout_known = ref_known[w];
    end
    e.err = ~valid;
    e.data = exp_dout;
    e.data_known = exp_dout_known;
    e.ack_cyc = cyc + 1 + (valid ? WC : 0);
    e.addr = a;
    sb_q.push_back(e);
    req = 1'b1; MemRead = rd; MemWrite = wr; addr = a; data_in = d;
    @(posedge clk);
    #1;
    req = 1'b0; MemRead = $urandom_range(0, 1); MemWrite = $urandom_range(0, 1);
    addr = $urandom; data_in = $urandom;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || sb_q.size() != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("drain_outstanding", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, d;
    int          k, op, w;
    int          pool [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 252, 253, 254, 255};

    repeat (3) @(negedge clk);
    check("reset_data_out", data_out, 32'd0);
    check("reset_ack", {31'd0, ack}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;

    // Zero wait states, req held high, address changing every cycle.
    @(negedge clk);
    for (int i = 1; i <= 16; i++) begin
      req0 = 1'b1;
      wr0 = (i <= 8);
      rd0 = (i > 8);
      addr0 = 32'(4 * ((i - 1) % 8));
      din0 = 32'h1000 + 32'(i);
      @(posedge clk);
      @(negedge clk);
      check("zw_ack_pattern", {31'd0, ack0}, {31'd0, (i % 2 == 1)});
      if (i % 2 == 1) check("zw_err", {31'd0, err0}, 32'd0);
      if (i > 8 && (i % 2 == 1)) check("zw_read_data", dout0, 32'h1000 + 32'(i - 8));
    end
    req0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;

    // Directed cases on the two-wait-state instance.
    issue(0, 1, 32'h10, 32'hDEADBEEF);
    issue(1, 0, 32'h10, 32'h0);
    issue(0, 1, 32'h13, 32'h55555555);
    issue(1, 0, 32'h10, 32'h0);
    issue(1, 0, 32'h400, 32'h0);
    issue(0, 1, 32'h3FC, 32'hCAFEF00D);
    issue(1, 0, 32'h3FC, 32'h0);
    issue(1, 1, 32'h10, 32'h00000BAD);
    issue(0, 0, 32'h10, 32'h00000BAD);
    issue(1, 0, 32'h10, 32'h0);
    issue(1, 0, 32'h80000010, 32'h0);
    issue(0, 1, 32'h20, 32'hA5A5A5A5);
    wait_idle();

    // Reset in the middle of a write's wait states abandons it.
    req = 1'b1; MemWrite = 1'b1; MemRead = 1'b0; addr = 32'h20; data_in = 32'h12345678;
    @(posedge clk);
    #1 req = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", {31'd0, busy}, 32'd0);
    check("mid_reset_ack", {31'd0, ack}, 32'd0);
    check("mid_reset_data_out", data_out, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_dout = 32'd0;
    exp_dout_known = 1'b1;
    issue(1, 0, 32'h20, 32'h0);

    for (int i = 0; i < 12; i++) issue(0, 1, 32'(pool[i] * 4), $urandom);

    for (int i = 0; i < 70; i++) begin
      k = $urandom_range(0, 9);
      op = $urandom_range(0, 9);
      w = pool[$urandom_range(0, 11)];
      d = $urandom;
      if (k <= 6) a = 32'(w * 4);
      else if (k == 7) a = 32'(w * 4) + 32'($urandom_range(1, 3));
      else if (k == 8) a = 32'($urandom_range(DEPTH, 1023) * 4);
      else a = (32'd1 << $urandom_range(10, 31)) | 32'(w * 4);
      if (op <= 3) issue(1, 0, a, d);
      else if (op <= 7) issue(0, 1, a, d);
      else if (op == 8) issue(1, 1, a, d);
      else issue(0, 0, a, d);
    end
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Multi-cycle data-memory responder: the target end of the CPU's load/store interface.
- Accepts one word read or write request at a time, inserts a programmable number of wait states, then completes with a one-cycle ack.
- Flags misaligned, out-of-range and malformed requests.
- Sits between the CPU datapath's load/store path and word-addressed data storage, so slow memories can be modelled.

Parameters:
DEPTH, 256, storage size in 32-bit words (power of two, 16..4096)
WAIT_CYCLES, 2, wait states inserted before completion (0..15)

Ports:
clk  input  1  positive-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  1  request valid; sampled only in IDLE
MemRead  input  1  read request qualifier
MemWrite  input  1  write request qualifier
addr  input  32  byte address
data_in  input  32  write data
data_out  output  32  read data (registered)
ack  output  1  one-cycle completion pulse
err  output  1  error status, valid only while ack=1
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, rst_n=0): FSM goes to IDLE. ack=0, err=0, busy=0, data_out=0, wait counter=0.
- Storage array is not reset; contents persist across reset.
- States: IDLE, WAIT, DONE. busy = (state != IDLE).
- IDLE, req=1 at a rising edge: the request is accepted. addr, data_in and op are latched.
- A request is valid only if all hold: exactly one of MemRead/MemWrite is 1, addr[1:0]==0, and addr[31:2] < DEPTH.
- Valid request with WAIT_CYCLES>0: next state WAIT, counter=WAIT_CYCLES.
- Valid request with WAIT_CYCLES=0: next state DONE.
- Invalid request: next state DONE directly, with err_pending=1. No array access occurs.
- IDLE, req=0: stay in IDLE.
- WAIT: counter decrements each edge. When counter==1, next state is DONE. Exactly WAIT_CYCLES cycles are spent in WAIT.
- Entry edge into DONE, valid write: mem[addr[log2(DEPTH)+1:2]] <= latched data.
- Entry edge into DONE, valid read: data_out <= mem[index].
- Entry edge into DONE, error: data_out <= 0.
- DONE: ack=1 and err=err_pending for exactly one cycle; next state is IDLE unconditionally.
- ack, err: 0 in every state other than DONE.
- data_out holds its value until the next DONE entry.
- Latency: counting the accepting edge as edge 1, ack is high in the cycle after edge WAIT_CYCLES+1. Invalid requests: ack is high in the cycle after edge 1.
- req, MemRead, MemWrite, addr and data_in changes while busy=1 are ignored. There is no queueing.
- The requester must drop req in the ack cycle. A req still high in the following IDLE cycle is accepted as a new request.
- Back-to-back throughput: one access per WAIT_CYCLES+2 cycles.
- Read-after-write to the same word returns the newly written data. No bypass is needed because accesses are serialised.
- Reset asserted in WAIT or DONE: the access is abandoned, the FSM returns to IDLE, and no array write occurs unless DONE had already been entered.
- Address wrap: none. Any addr[31:2] >= DEPTH is an error; upper bits are never truncated.

Test Plan:
- WAIT_CYCLES=2. Write 0xDEADBEEF to addr 0x10, then read 0x10 → each ack arrives 3 cycles after acceptance; read data_out=0xDEADBEEF, err=0.
- Write to addr 0x13 (misaligned) → ack at 1 cycle, err=1, data_out=0; a subsequent read of 0x10 still returns its prior value.
- DEPTH=256. Read addr 0x400 (word 256) → err=1. Read 0x3FC (word 255) → err=0.
- MemRead=MemWrite=1 with req=1 → err=1, no write. MemRead=MemWrite=0 → err=1.
- Assert rst_n=0 during WAIT of a write of 0x12345678 to 0x20 → ack never pulses, busy=0. Reading 0x20 afterwards returns its old value.
- WAIT_CYCLES=0. Hold req high with alternating addr → accesses complete every 2 cycles; the ack pattern is 0,1,0,1; changes to addr while busy are ignored.
